spi_sample_rx: RTL and testbench
================================

SPI_SAMPLE_RX -- requirements
Module: spi_sample_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits per sample word (4..32).
REQ-002 SHALL have parameter NUM_CH, default 2, meaning words per frame (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning output FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter SAMPLE_EDGE, default 0, meaning mosi capture edge: 0 = sclk rising, 1 = sclk falling.
REQ-005 SHALL have parameter MSB_FIRST, default 1, meaning bit order: 1 = MSB first, 0 = LSB first.
REQ-006 SHALL have port clk_25mhz, input, 1 bit: the only clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port sclk_in, input, 1 bit: serial clock from the Pico, asynchronous.
REQ-009 SHALL have port mosi_in, input, 1 bit: serial data, asynchronous.
REQ-010 SHALL have port active, input, 1 bit: frame enable from the Pico, high while transferring, asynchronous.
REQ-011 SHALL have port out_data, output, DATA_W bits: FIFO head word.
REQ-012 SHALL have port out_ch, output, CH_W = max(1,$clog2(NUM_CH)) bits: channel index of out_data.
REQ-013 SHALL have port out_valid, output, 1 bit: FIFO head valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the head word when out_valid && out_ready.
REQ-015 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-016 SHALL have port overflow, output, 1 bit: sticky; set when a word is dropped.
REQ-017 SHALL have port frame_err, output, 1 bit: one-cycle pulse on an aborted or incomplete frame.

Function
REQ-018 sclk_in, mosi_in and active SHALL each pass through a 2-flop synchronizer; sclk SHALL get one extra stage for edge detection.
REQ-019 The capture strobe SHALL be a one-cycle pulse on the synchronized edge selected by SAMPLE_EDGE; mosi SHALL be sampled from the aligned synchronized stage.
REQ-020 FSM states SHALL be IDLE and RECEIVING; IDLE->RECEIVING on synchronized active=1, clearing the bit counter, shift register and channel counter.
REQ-021 In RECEIVING, each strobe SHALL shift in one bit, left-shift if MSB_FIRST=1 and right-shift otherwise.
REQ-022 On the DATA_W-th strobe, the completed word, including the current bit, and the channel counter SHALL be pushed into the FIFO in that same cycle; the bit counter SHALL return to 0.
REQ-023 The channel counter SHALL increment per completed word and wrap NUM_CH-1 -> 0.
REQ-024 RECEIVING->IDLE on synchronized active=0; a nonzero bit counter or nonzero channel counter SHALL pulse frame_err for one cycle and discard the partial word.
REQ-025 FIFO SHALL be first-word-fall-through: a pushed word SHALL appear on out_data/out_ch with out_valid=1 on the cycle after the push when the FIFO was empty.
REQ-026 Pop SHALL occur on out_valid && out_ready; out_data SHALL remain stable while out_valid=1 && out_ready=0.
REQ-027 A push when full without a same-cycle pop SHALL drop the new word and set overflow; full with a same-cycle pop SHALL accept the push and leave the level unchanged.
REQ-028 A pop when empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 Frame-level framing errors SHALL NOT flush words already in the FIFO.

Reset
REQ-030 On reset: state=IDLE, all counters and the shift register = 0, FIFO empty, out_valid=0, out_data=0, out_ch=0, fifo_level=0, overflow=0, frame_err=0, synchronizers=0.
REQ-031 Reset mid-word or mid-frame SHALL take effect immediately (async) and discard all stored data; there SHALL be no frame_err pulse.

Structure
REQ-032 Package comm_pkg SHALL hold rx_state_t (IDLE, RECEIVING) and the default width constants.
REQ-033 The FIFO SHALL be a separate sub-module sample_fifo, parametrised by width (DATA_W+CH_W) and FIFO_DEPTH.

Verification
REQ-034 DATA_W=16, NUM_CH=2, MSB first, rising edge: send 0xA5C3 then 0x0F0F -> out_data 0xA5C3/ch0, then 0x0F0F/ch1, frame_err=0.
REQ-035 Drop active after 9 bits -> frame_err pulses once, FIFO level unchanged, next frame's first word has ch0.
REQ-036 out_ready=0, stream 9 words with FIFO_DEPTH=8 -> fifo_level=8, overflow=1, 9th word absent, words 1..8 drained in order.
REQ-037 SAMPLE_EDGE=1, MSB_FIRST=0, send 0x0001 LSB first -> out_data=0x0001.
REQ-038 Full FIFO, out_ready=1 on the same cycle as a push -> level stays 8, overflow stays 0.
REQ-039 Assert reset mid-word -> all outputs 0 within the same cycle; the next full word is received correctly with ch0.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared types and default sizing for the SPI sample receiver.
package comm_pkg;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    RECEIVING = 1'b1
  } rx_state_t;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_FIFO_DEPTH = 8;

  // Channel index width; a single-channel build still carries a 1-bit index.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO holding {channel, sample} entries.
module sample_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                    clk_25mhz,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic                    head_valid,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
  always_comb begin
    full    = (count == CNT_FULL);
    do_pop  = pop && (count != '0);
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
  end

  // Storage array; contents are only observable through a valid head, so no reset is needed.
  always_ff @(posedge clk_25mhz) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; overflow stays set until reset.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Head word is forced to zero while empty so stale storage never leaks out.
  always_comb begin
    head_valid = (count != '0);
    head_data  = head_valid ? mem[rd_ptr] : '0;
    level      = count;
  end

endmodule

// File: rtl/spi_sample_rx.sv
// SPI slave receiver: synchronizes the Pico's bus, assembles framed sample words
// tagged with a channel index and queues them in a FWFT FIFO.
module spi_sample_rx
  import comm_pkg::*;
#(
  parameter int  DATA_W      = DEF_DATA_W,
  parameter int  NUM_CH      = DEF_NUM_CH,
  parameter int  FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int  SAMPLE_EDGE = 0,
  parameter int  MSB_FIRST   = 1,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic                          clk_25mhz,
  input  logic                          reset,
  input  logic                          sclk_in,
  input  logic                          mosi_in,
  input  logic                          active,
  output logic [DATA_W-1:0]             out_data,
  output logic [CH_W-1:0]               out_ch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] BIT_ONE  = 1;
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_ONE   = 1;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1;
  logic active_p0, active_p1;
  logic strobe;

  rx_state_t          state, state_nxt;
  logic [BC_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [CH_W-1:0]    ch_cnt, ch_cnt_nxt;
  logic [DATA_W-1:0]  shift_reg, shift_nxt, shifted;
  logic               frame_err_nxt;
  logic               push;
  logic [CH_W+DATA_W-1:0] push_data;
  logic [CH_W+DATA_W-1:0] head_data;

  // Input synchronizers; sclk carries a third stage so edges can be detected on stable data.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      sclk_p0   <= 1'b0;
      sclk_p1   <= 1'b0;
      sclk_p2   <= 1'b0;
      mosi_p0   <= 1'b0;
      mosi_p1   <= 1'b0;
      active_p0 <= 1'b0;
      active_p1 <= 1'b0;
    end else begin
      sclk_p0   <= sclk_in;
      sclk_p1   <= sclk_p0;
      sclk_p2   <= sclk_p1;
      mosi_p0   <= mosi_in;
      mosi_p1   <= mosi_p0;
      active_p0 <= active;
      active_p1 <= active_p0;
    end
  end

  // Capture strobe on the chosen sclk edge, with the incoming bit merged in the configured order.
  always_comb begin
    if (SAMPLE_EDGE != 0) begin
      strobe = ~sclk_p1 & sclk_p2;
    end else begin
      strobe = sclk_p1 & ~sclk_p2;
    end
    if (MSB_FIRST != 0) begin
      shifted = {shift_reg[DATA_W-2:0], mosi_p1};
    end else begin
      shifted = {mosi_p1, shift_reg[DATA_W-1:1]};
    end
  end

  // Frame FSM: word assembly, channel tagging and abort detection.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    ch_cnt_nxt    = ch_cnt;
    shift_nxt     = shift_reg;
    frame_err_nxt = 1'b0;
    push          = 1'b0;
    case (state)
      IDLE: begin
        if (active_p1) begin
          state_nxt   = RECEIVING;
          bit_cnt_nxt = '0;
          ch_cnt_nxt  = '0;
          shift_nxt   = '0;
        end
      end
      RECEIVING: begin
        if (!active_p1) begin
          state_nxt     = IDLE;
          frame_err_nxt = (bit_cnt != '0) || (ch_cnt != '0);
          bit_cnt_nxt   = '0;
          ch_cnt_nxt    = '0;
          shift_nxt     = '0;
        end else if (strobe) begin
          shift_nxt = shifted;
          if (bit_cnt == BIT_LAST) begin
            push        = 1'b1;
            bit_cnt_nxt = '0;
            ch_cnt_nxt  = (ch_cnt == CH_LAST) ? '0 : ch_cnt + CH_ONE;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_ONE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, counters and the registered frame error pulse.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ch_cnt    <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ch_cnt    <= ch_cnt_nxt;
      shift_reg <= shift_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  assign push_data = {ch_cnt, shifted};

  sample_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_25mhz  (clk_25mhz),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (out_ready),
    .head_data  (head_data),
    .head_valid (out_valid),
    .level      (fifo_level),
    .overflow   (overflow)
  );

  assign out_ch   = head_data[CH_W+DATA_W-1:DATA_W];
  assign out_data = head_data[DATA_W-1:0];

endmodule

// File: tb/tb_spi_sample_rx.sv
// Directed bench for spi_sample_rx: a default instance plus an LSB-first,
// falling-edge, single-channel instance sharing the same serial bus.
`timescale 1ns/1ps
module tb_spi_sample_rx;

  localparam int HALF = 160;

  logic        clk_25mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        sclk_in   = 1'b0;
  logic        mosi_in   = 1'b0;
  logic        active    = 1'b0;
  logic        out_ready = 1'b0;
  logic        ready2    = 1'b0;

  logic [15:0] out_data;
  logic [0:0]  out_ch;
  logic        out_valid;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        frame_err;

  logic [15:0] out_data2;
  logic [0:0]  out_ch2;
  logic        out_valid2;
  logic [3:0]  fifo_level2;
  logic        overflow2;
  logic        frame_err2;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int err2_cnt = 0;
  int base;
  int base2;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] exp_d0;
    logic [0:0]  exp_c0;
    logic [15:0] exp_d1;
    logic [0:0]  exp_c1;
    logic [3:0]  exp_lvl;
  } vec_t;

  vec_t vecs[4];

  always #20 clk_25mhz = ~clk_25mhz;

  spi_sample_rx #(
    .DATA_W(16), .NUM_CH(2), .FIFO_DEPTH(8), .SAMPLE_EDGE(0), .MSB_FIRST(1)
  ) dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .sclk_in(sclk_in), .mosi_in(mosi_in),
    .active(active), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow),
    .frame_err(frame_err)
  );

  spi_sample_rx #(
    .DATA_W(16), .NUM_CH(1), .FIFO_DEPTH(8), .SAMPLE_EDGE(1), .MSB_FIRST(0)
  ) dut2 (
    .clk_25mhz(clk_25mhz), .reset(reset), .sclk_in(sclk_in), .mosi_in(mosi_in),
    .active(active), .out_data(out_data2), .out_ch(out_ch2), .out_valid(out_valid2),
    .out_ready(ready2), .fifo_level(fifo_level2), .overflow(overflow2),
    .frame_err(frame_err2)
  );

  always @(negedge clk_25mhz) begin
    if (frame_err === 1'b1) err_cnt++;
    if (frame_err2 === 1'b1) err2_cnt++;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    mosi_in = b;
    #HALF;
    sclk_in = 1'b1;
    #HALF;
    sclk_in = 1'b0;
    #HALF;
  endtask

  task automatic send_word(input logic [15:0] w, input bit msb);
    for (int i = 0; i < 16; i++) send_bit(msb ? w[15-i] : w[i]);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[15-i]);
  endtask

  task automatic begin_frame();
    @(negedge clk_25mhz);
    active = 1'b1;
    repeat (6) @(negedge clk_25mhz);
  endtask

  task automatic end_frame();
    @(negedge clk_25mhz);
    active = 1'b0;
    repeat (6) @(negedge clk_25mhz);
  endtask

  task automatic pop_one();
    @(negedge clk_25mhz);
    out_ready = 1'b1;
    @(negedge clk_25mhz);
    out_ready = 1'b0;
  endtask

  task automatic drain_check(input string name, input logic [15:0] d, input logic [0:0] c);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_data"}, {16'd0, out_data}, {16'd0, d});
    check({name, "_ch"}, {31'd0, out_ch}, {31'd0, c});
    pop_one();
  endtask

  task automatic apply_reset();
    @(negedge clk_25mhz);
    reset = 1'b1;
    @(negedge clk_25mhz);
    reset = 1'b0;
    repeat (2) @(negedge clk_25mhz);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 16'h0F0F, 16'hA5C3, 1'b0, 16'h0F0F, 1'b1, 4'd2};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'd2};
    vecs[2] = '{16'h8001, 16'h7FFE, 16'h8001, 1'b0, 16'h7FFE, 1'b1, 4'd2};
    vecs[3] = '{16'h1234, 16'hABCD, 16'h1234, 1'b0, 16'hABCD, 1'b1, 4'd2};

    // Reset state
    #5;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_ch", {31'd0, out_ch}, 32'd0);
    check("rst_level", {28'd0, fifo_level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk_25mhz);
    reset = 1'b0;
    repeat (3) @(negedge clk_25mhz);

    // Two-word frames, table driven
    for (int v = 0; v < 4; v++) begin
      base = err_cnt;
      begin_frame();
      send_word(vecs[v].w0, 1'b1);
      send_word(vecs[v].w1, 1'b1);
      end_frame();
      check($sformatf("vec%0d_level", v), {28'd0, fifo_level}, {28'd0, vecs[v].exp_lvl});
      drain_check($sformatf("vec%0d_w0", v), vecs[v].exp_d0, vecs[v].exp_c0);
      drain_check($sformatf("vec%0d_w1", v), vecs[v].exp_d1, vecs[v].exp_c1);
      check($sformatf("vec%0d_empty", v), {31'd0, out_valid}, 32'd0);
      check($sformatf("vec%0d_frame_err", v), err_cnt - base, 32'd0);
    end

    // Aborted frames keep queued words and restart at channel 0
    begin_frame();
    send_word(16'h1111, 1'b1);
    send_word(16'h2222, 1'b1);
    end_frame();
    base = err_cnt;
    begin_frame();
    send_bits(16'hFFFF, 9);
    end_frame();
    check("abort9_err", err_cnt - base, 32'd1);
    check("abort9_level", {28'd0, fifo_level}, 32'd2);
    base = err_cnt;
    begin_frame();
    send_word(16'h3333, 1'b1);
    end_frame();
    check("abort_ch_err", err_cnt - base, 32'd1);
    check("abort_ch_level", {28'd0, fifo_level}, 32'd3);
    begin_frame();
    send_word(16'h4444, 1'b1);
    send_word(16'h5555, 1'b1);
    end_frame();
    drain_check("ab_1111", 16'h1111, 1'b0);
    drain_check("ab_2222", 16'h2222, 1'b1);
    drain_check("ab_3333", 16'h3333, 1'b0);
    drain_check("ab_4444", 16'h4444, 1'b0);
    drain_check("ab_5555", 16'h5555, 1'b1);

    // Overflow: nine words into eight slots with no consumer
    base = err_cnt;
    begin_frame();
    for (int i = 0; i < 9; i++) send_word(16'hA000 + 16'(i), 1'b1);
    end_frame();
    check("ovf_level", {28'd0, fifo_level}, 32'd8);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_odd_frame_err", err_cnt - base, 32'd1);
    for (int i = 0; i < 8; i++)
      drain_check($sformatf("ovf_w%0d", i), 16'hA000 + 16'(i), 1'(i % 2));
    check("ovf_drained", {31'd0, out_valid}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Full FIFO with a pop in the push cycle
    apply_reset();
    check("full_pop_ovf0", {31'd0, overflow}, 32'd0);
    begin_frame();
    for (int i = 0; i < 8; i++) send_word(16'hB000 + 16'(i), 1'b1);
    end_frame();
    check("full_level", {28'd0, fifo_level}, 32'd8);
    begin_frame();
    send_bits(16'hB008, 15);
    mosi_in = 1'b0;
    #HALF;
    @(negedge clk_25mhz);
    sclk_in = 1'b1;
    @(negedge clk_25mhz);
    @(negedge clk_25mhz);
    out_ready = 1'b1;
    @(negedge clk_25mhz);
    out_ready = 1'b0;
    check("full_pop_level", {28'd0, fifo_level}, 32'd8);
    check("full_pop_overflow", {31'd0, overflow}, 32'd0);
    #HALF;
    sclk_in = 1'b0;
    #HALF;
    end_frame();
    for (int i = 1; i < 8; i++)
      drain_check($sformatf("fp_w%0d", i), 16'hB000 + 16'(i), 1'(i % 2));
    drain_check("fp_w8", 16'hB008, 1'b0);
    check("fp_drained", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-word
    begin_frame();
    send_word(16'h6666, 1'b1);
    send_word(16'h7777, 1'b1);
    end_frame();
    check("mid_pre_level", {28'd0, fifo_level}, 32'd2);
    base = err_cnt;
    begin_frame();
    send_bits(16'h5A5A, 7);
    #7;
    reset = 1'b1;
    #1;
    check("mid_rst_level", {28'd0, fifo_level}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {16'd0, out_data}, 32'd0);
    check("mid_rst_ch", {31'd0, out_ch}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    active = 1'b0;
    repeat (2) @(negedge clk_25mhz);
    reset = 1'b0;
    repeat (6) @(negedge clk_25mhz);
    check("mid_rst_no_err", err_cnt - base, 32'd0);
    begin_frame();
    send_word(16'hBEEF, 1'b1);
    send_word(16'h0123, 1'b1);
    end_frame();
    drain_check("mid_beef", 16'hBEEF, 1'b0);
    drain_check("mid_0123", 16'h0123, 1'b1);
    check("mid_frame_err", err_cnt - base, 32'd0);

    // LSB-first, falling-edge capture on the second instance
    apply_reset();
    base2 = err2_cnt;
    begin_frame();
    send_word(16'h0001, 1'b0);
    end_frame();
    check("lsb_level", {28'd0, fifo_level2}, 32'd1);
    check("lsb_valid", {31'd0, out_valid2}, 32'd1);
    check("lsb_data", {16'd0, out_data2}, 32'h0001);
    check("lsb_ch", {31'd0, out_ch2}, 32'd0);
    check("lsb_no_err", err2_cnt - base2, 32'd0);
    check("msb_view_data", {16'd0, out_data}, 32'h8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
